// File: rtl/surf_cout_capture_ctrl.sv
// Arbitrated SURF COUT read controller: freezes one channel, waits SETTLE cycles,
// samples its captured word and releases it; also keeps per-channel bit-error counters.
module surf_cout_capture_ctrl #(
  parameter int unsigned NCHAN  = 7,
  parameter int unsigned SETTLE = 4
) (
  input  logic                sysclk_i,
  input  logic                rstn_i,
  input  logic [NCHAN*32-1:0] cout_parallel_i,
  input  logic [NCHAN-1:0]    biterr_i,
  output logic [NCHAN-1:0]    capture_o,
  output logic [NCHAN-1:0]    captured_o,
  input  logic                a_req_i,
  input  logic                b_req_i,
  input  logic [2:0]          a_chan_i,
  input  logic [2:0]          b_chan_i,
  output logic                a_ack_o,
  output logic                b_ack_o,
  output logic [31:0]         rdata_o,
  input  logic [2:0]          err_sel_i,
  input  logic                errclr_i,
  output logic [15:0]         errcnt_o
);

  typedef enum logic [2:0] {
    ST_RELEASE, ST_IDLE, ST_FREEZE, ST_SETTLE, ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ch_q;
  logic        gnt_b_q;
  logic        last_b_q;
  logic [3:0]  settle_q;
  logic [31:0] rdata_q;
  logic        grant_a, grant_b, grant_valid;
  logic [2:0]  grant_ch;
  logic [31:0] words [NCHAN];
  logic [15:0] errcnt_q [NCHAN];

  always_comb begin
    for (int unsigned k = 0; k < NCHAN; k++) begin
      words[k] = cout_parallel_i[32*k +: 32];
    end
  end

  // On contention the requester that was not served last wins.
  always_comb begin
    grant_a     = a_req_i && (!b_req_i || last_b_q);
    grant_b     = b_req_i && (!a_req_i || !last_b_q);
    grant_ch    = grant_b ? b_chan_i : a_chan_i;
    grant_valid = ({1'b0, grant_ch} < 4'(NCHAN));
  end

  always_ff @(posedge sysclk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_RELEASE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RELEASE: state_d = ST_IDLE;
      ST_IDLE:    if (grant_a || grant_b) state_d = grant_valid ? ST_FREEZE : ST_DONE;
      ST_FREEZE:  state_d = ST_SETTLE;
      ST_SETTLE:  if (settle_q == 4'd0) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_RELEASE;
    endcase
  end

  always_ff @(posedge sysclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ch_q     <= '0;
      gnt_b_q  <= 1'b0;
      last_b_q <= 1'b1;
      settle_q <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (grant_a || grant_b) begin
          ch_q     <= grant_ch;
          gnt_b_q  <= grant_b;
          last_b_q <= grant_b;
          if (!grant_valid) rdata_q <= '0;
        end
        ST_FREEZE: settle_q <= 4'(SETTLE - 1);
        ST_SETTLE: begin
          if (settle_q == 4'd0) rdata_q <= words[ch_q];
          else                  settle_q <= settle_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // RELEASE is also the reset state, so its all-ones pulse is masked while reset is held.
  always_comb begin
    capture_o  = '0;
    captured_o = '0;
    for (int unsigned k = 0; k < NCHAN; k++) begin
      capture_o[k]  = (state_q == ST_FREEZE) && (ch_q == 3'(k));
      captured_o[k] = ((state_q == ST_RELEASE) && rstn_i) ||
                      ((state_q == ST_DONE) && (ch_q == 3'(k)));
    end
    a_ack_o = (state_q == ST_DONE) && !gnt_b_q;
    b_ack_o = (state_q == ST_DONE) && gnt_b_q;
    rdata_o = rdata_q;
  end

  always_ff @(posedge sysclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned k = 0; k < NCHAN; k++) errcnt_q[k] <= '0;
      errcnt_o <= '0;
    end else begin
      for (int unsigned k = 0; k < NCHAN; k++) begin
        if (errclr_i && (err_sel_i == 3'(k)))
          errcnt_q[k] <= {15'd0, biterr_i[k]};
        else if (biterr_i[k] && (errcnt_q[k] != '1))
          errcnt_q[k] <= errcnt_q[k] + 16'd1;
      end
      errcnt_o <= ({1'b0, err_sel_i} < 4'(NCHAN)) ? errcnt_q[err_sel_i] : '0;
    end
  end

endmodule

// File: tb/tb_surf_cout_capture_ctrl.sv
// Scoreboard bench for surf_cout_capture_ctrl: randomized requests and bit errors
// checked against a cycle-level transaction model.
module tb_surf_cout_capture_ctrl;
  localparam int unsigned NCHAN  = 7;
  localparam int unsigned SETTLE = 4;
  localparam int          LAT    = SETTLE + 2;

  logic                clk = 1'b0;
  logic                rstn = 1'b1;
  logic [NCHAN*32-1:0] cout_parallel = '0;
  logic [NCHAN-1:0]    biterr = '0;
  logic [NCHAN-1:0]    capture, captured;
  logic                a_req = 1'b0, b_req = 1'b0;
  logic [2:0]          a_chan = '0, b_chan = '0;
  logic                a_ack, b_ack;
  logic [31:0]         rdata;
  logic [2:0]          err_sel = '0;
  logic                errclr = 1'b0;
  logic [15:0]         errcnt;

  always #5 clk = ~clk;

  surf_cout_capture_ctrl #(.NCHAN(NCHAN), .SETTLE(SETTLE)) dut (
    .sysclk_i(clk), .rstn_i(rstn), .cout_parallel_i(cout_parallel), .biterr_i(biterr),
    .capture_o(capture), .captured_o(captured),
    .a_req_i(a_req), .b_req_i(b_req), .a_chan_i(a_chan), .b_chan_i(b_chan),
    .a_ack_o(a_ack), .b_ack_o(b_ack), .rdata_o(rdata),
    .err_sel_i(err_sel), .errclr_i(errclr), .errcnt_o(errcnt)
  );

  typedef struct { bit is_b; logic [31:0] data; int cyc; } exp_t;
  exp_t             sbq[$];
  logic [NCHAN-1:0] exp_cap  [int];
  logic [NCHAN-1:0] exp_capd [int];
  logic [31:0]      words [NCHAN];
  int               tests = 0, fails = 0;
  int               cyc = 0;
  bit               last_b_m = 1'b1;
  int               mode = 0;
  int unsigned      m_cnt [NCHAN];
  logic [15:0]      exp_err = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Error-counter reference: per-cycle count with saturation, clear wins over the old value.
  always @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NCHAN; k++) m_cnt[k] = 0;
      exp_err = '0;
    end else begin
      exp_err = (err_sel < NCHAN) ? 16'(m_cnt[err_sel]) : 16'd0;
      for (int k = 0; k < NCHAN; k++) begin
        if (errclr && err_sel == 3'(k)) m_cnt[k] = biterr[k] ? 1 : 0;
        else if (biterr[k])             m_cnt[k] = (m_cnt[k] >= 65535) ? 65535 : m_cnt[k] + 1;
      end
    end
  end

  always @(posedge clk) begin : errgen
    int m;
    m = mode;
    #1;
    if (m == 0) begin
      for (int k = 0; k < NCHAN; k++) biterr[k] = ($urandom_range(0, 3) == 0);
      err_sel = 3'($urandom_range(0, 7));
      errclr  = ($urandom_range(0, 15) == 0);
    end else begin
      biterr    = '0;
      biterr[3] = 1'b1;
      err_sel   = 3'd3;
      errclr    = (m == 2);
    end
  end

  always @(negedge clk) begin : monitor
    logic [NCHAN-1:0] e;
    logic [15:0]      ee;
    exp_t             x;
    e = exp_cap.exists(cyc) ? exp_cap[cyc] : '0;
    tests++;
    if (capture !== e) begin
      fails++;
      $display("FAIL capture_o cyc=%0d got=%h exp=%h", cyc, capture, e);
    end
    e = exp_capd.exists(cyc) ? exp_capd[cyc] : '0;
    tests++;
    if (captured !== e) begin
      fails++;
      $display("FAIL captured_o cyc=%0d got=%h exp=%h", cyc, captured, e);
    end
    ee = rstn ? exp_err : 16'd0;
    tests++;
    if (errcnt !== ee) begin
      fails++;
      $display("FAIL errcnt_o cyc=%0d got=%h exp=%h", cyc, errcnt, ee);
    end
    if (a_ack || b_ack) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack cyc=%0d a=%b b=%b", cyc, a_ack, b_ack);
      end else begin
        x = sbq.pop_front();
        if ({a_ack, b_ack} !== (x.is_b ? 2'b01 : 2'b10) || rdata !== x.data || cyc != x.cyc) begin
          fails++;
          $display("FAIL ack cyc=%0d a=%b b=%b rdata=%h exp: is_b=%b rdata=%h cyc=%0d",
                   cyc, a_ack, b_ack, rdata, x.is_b, x.data, x.cyc);
        end
      end
    end
  end

  task automatic rand_words();
    for (int k = 0; k < NCHAN; k++) words[k] = $urandom;
  endtask

  // Records one expected read served from the IDLE cycle `idle`; returns its ack cycle.
  function automatic int push(input bit isb, input logic [2:0] ch, input int idle);
    exp_t e;
    int   l;
    e.is_b = isb;
    e.data = '0;
    l = 1;
    if (ch < NCHAN) begin
      l = LAT;
      e.data = words[ch];
      exp_cap[idle + 1]  = NCHAN'(1) << ch;
      exp_capd[idle + l] = NCHAN'(1) << ch;
    end
    e.cyc = idle + l;
    sbq.push_back(e);
    return idle + l;
  endfunction

  task automatic wait_idle_and_check(input int budget);
    while ((a_req || b_req) && budget > 0) begin
      @(negedge clk);
      if (a_ack) a_req = 1'b0;
      if (b_ack) b_req = 1'b0;
      budget--;
    end
    if (a_req || b_req) begin
      tests++;
      fails++;
      $display("FAIL txn_timeout cyc=%0d a_req=%b b_req=%b", cyc, a_req, b_req);
      a_req = 1'b0;
      b_req = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // Called #1 after a posedge with the DUT in IDLE.
  task automatic txn(input bit ua, input bit ub, input logic [2:0] ca, input logic [2:0] cb);
    int n, a1;
    bit fb;
    n = cyc;
    for (int k = 0; k < NCHAN; k++) cout_parallel[32*k +: 32] = words[k];
    a_chan = ca;
    b_chan = cb;
    a_req  = ua;
    b_req  = ub;
    fb = ub && (!ua || !last_b_m);
    a1 = push(fb, fb ? cb : ca, n);
    last_b_m = fb;
    if (ua && ub) begin
      void'(push(!fb, fb ? ca : cb, a1 + 1));
      last_b_m = !fb;
    end
    wait_idle_and_check(3 * (LAT + 2));
  endtask

  task automatic alt(input int ngr);
    int  idle, got, budget;
    bit  isb;
    for (int k = 0; k < NCHAN; k++) cout_parallel[32*k +: 32] = words[k];
    a_chan = 3'd0;
    b_chan = 3'd1;
    a_req  = 1'b1;
    b_req  = 1'b1;
    idle = cyc;
    isb  = !last_b_m;
    for (int i = 0; i < ngr; i++) begin
      idle = push(isb, isb ? 3'd1 : 3'd0, idle) + 1;
      last_b_m = isb;
      isb = !isb;
    end
    got = 0;
    budget = ngr * (LAT + 1) + 10;
    while (got < ngr && budget > 0) begin
      @(negedge clk);
      if (a_ack || b_ack) got++;
      if (got == ngr) begin a_req = 1'b0; b_req = 1'b0; end
      budget--;
    end
    if (got < ngr) begin
      tests++;
      fails++;
      $display("FAIL alt_timeout got=%0d exp=%0d", got, ngr);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    sbq.delete();
    exp_cap.delete();
    exp_capd.delete();
    last_b_m = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (rdata !== 32'h0 || a_ack !== 1'b0 || b_ack !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs rdata=%h a_ack=%b b_ack=%b exp 0/0/0", rdata, a_ack, b_ack);
      end
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_capd[cyc] = '1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, kind;
    #1;
    do_reset();

    rand_words();
    words[2] = 32'h1234_5678;
    txn(1'b1, 1'b0, 3'd2, 3'd0);
    rand_words();
    txn(1'b0, 1'b1, 3'd0, 3'd7);

    do_reset();
    rand_words();
    alt(6);

    for (int i = 0; i < 60; i++) begin
      rand_words();
      kind = $urandom_range(0, 2);
      txn(kind != 1, kind != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // Abort a read in the middle of its settle window.
    rand_words();
    for (int k = 0; k < NCHAN; k++) cout_parallel[32*k +: 32] = words[k];
    n = cyc;
    a_chan = 3'd3;
    a_req  = 1'b1;
    exp_cap[n + 1] = NCHAN'(1) << 3;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    rand_words();
    txn(1'b1, 1'b0, 3'd5, 3'd0);

    mode = 1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    tests++;
    if (errcnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL errcnt_saturate got=%h exp=ffff", errcnt);
    end
    @(posedge clk); #1;
    mode = 2;
    @(posedge clk); #1;
    mode = 1;
    @(negedge clk);
    tests++;
    if (errcnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL errcnt_before_clear got=%h exp=ffff", errcnt);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (errcnt !== 16'h0001) begin
      fails++;
      $display("FAIL errcnt_clear_with_err got=%h exp=0001", errcnt);
    end
    @(posedge clk); #1;
    mode = 0;

    for (int i = 0; i < 20; i++) begin
      rand_words();
      kind = $urandom_range(0, 2);
      txn(kind != 1, kind != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL missing_acks got=%0d exp=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/surf_cout_capture_ctrl.md
SURF_COUT_CAPTURE_CTRL -- requirements
Module: surf_cout_capture_ctrl

Interface
REQ-001 Parameter NCHAN, default 7: number of SURF COUT channels served (1..8).
REQ-002 Parameter SETTLE, default 4: cycles between freeze pulse and data sample (1..15).
REQ-003 sysclk_i  in  1  sole clock; all logic is on its rising edge.
REQ-004 rstn_i  in  1  asynchronous, active-low reset.
REQ-005 cout_parallel_i  in  NCHAN*32  per-channel captured COUT words; channel k occupies bits [32k +: 32].
REQ-006 biterr_i  in  NCHAN  per-channel COUT bit-error flags, one bit per sysclk.
REQ-007 capture_o  out  NCHAN  one-cycle freeze pulse per channel.
REQ-008 captured_o  out  NCHAN  one-cycle release pulse per channel.
REQ-009 a_req_i / b_req_i  in  1 each  read requests from requester A (register core) and requester B (housekeeping scanner).
REQ-010 a_chan_i / b_chan_i  in  3 each  requested channel; held stable while the matching req is high.
REQ-011 a_ack_o / b_ack_o  out  1 each  one-cycle completion pulse to the granted requester.
REQ-012 rdata_o  out  32  read data; valid during ack and held until the next ack.
REQ-013 err_sel_i  in  3  selects the error counter shown on errcnt_o.
REQ-014 errclr_i  in  1  clears the selected error counter.
REQ-015 errcnt_o  out  16  registered value of the selected error counter.

Function
REQ-016 FSM states: RELEASE, IDLE, FREEZE, SETTLE, DONE.
REQ-017 RELEASE: captured_o asserts all-ones for one cycle, then the FSM enters IDLE.
REQ-018 IDLE arbitration, A only requesting: A is granted.
REQ-019 IDLE arbitration, B only requesting: B is granted.
REQ-020 IDLE arbitration, both requesting: the requester not granted last is granted; last_grant is registered.
REQ-021 On grant: the granted channel is latched; state advances to FREEZE, or directly to DONE if the channel is >= NCHAN.
REQ-022 FREEZE: capture_o[ch] is 1 for exactly one cycle; state advances to SETTLE; the settle counter loads SETTLE-1.
REQ-023 SETTLE: the counter decrements each cycle; at 0, rdata_o loads cout_parallel_i[ch] and the state advances to DONE.
REQ-024 DONE: the granted ack pulses for one cycle.
REQ-025 DONE, valid channel: captured_o[ch] is 1 for that same cycle.
REQ-026 DONE, invalid channel: rdata_o is 0x00000000 and no capture_o/captured_o bit asserts.
REQ-027 After DONE the FSM returns to IDLE.
REQ-028 Latency, valid channel: ack occurs SETTLE+2 cycles after the IDLE cycle that samples req.
REQ-029 Latency, invalid channel: ack occurs 1 cycle after the sampling cycle.
REQ-030 Req is sampled only in IDLE; a req still high in the IDLE cycle after DONE is a new request.
REQ-031 At most one capture_o bit and one captured_o bit is high in any cycle, except the all-ones RELEASE pulse.
REQ-032 Error counters: NCHAN 16-bit counters; +1 per cycle with biterr_i[k]=1; saturate at 0xFFFF.
REQ-033 errclr_i clears only counter err_sel_i.
REQ-034 errclr_i coincident with biterr_i on the same counter: the counter becomes 1.
REQ-035 errcnt_o = counter[err_sel_i], registered with 1-cycle latency; 0 if err_sel_i >= NCHAN.

Reset
REQ-036 While rstn_i is low: state=RELEASE, capture_o=0, captured_o=0, acks=0, rdata_o=0, errcnt_o=0, all counters=0, last_grant=B.
REQ-037 Reset mid-transaction aborts it with no ack, and the RELEASE pulse after deassertion unfreezes any held channel.

Verification
REQ-038 Reset release: captured_o=7'h7F for one cycle, then 0; no ack.
REQ-039 SETTLE=4, a_req with chan=2, cout word 2=0x12345678: capture_o=7'h04 at cycle+1; a_ack_o and captured_o=7'h04 at cycle+6; rdata_o=0x12345678.
REQ-040 a_req and b_req both held continuously, chans 0/1: grants alternate A,B,A,B, and A is first after reset.
REQ-041 b_req with chan=7, NCHAN=7: b_ack_o at cycle+1, rdata_o=0, capture_o and captured_o stay 0.
REQ-042 biterr_i[3] high for 70000 cycles, err_sel_i=3: errcnt_o=0xFFFF; errclr_i plus biterr_i[3] in the same cycle gives errcnt_o=1 two cycles later.
REQ-043 rstn_i low during SETTLE: no ack; after release captured_o=all-ones once; a following request completes normally.
